// File: rtl/ibex_regcache_writeback.sv
// Write-back drain buffer between the register write cache and the backing flop register file.
// Define REGCACHE_WB_COALESCE_EN to merge evictions that hit an address already pending.
//
// state   | meaning
// S_IDLE  | normal operation, evictions accepted while space exists
// S_DRAIN | flush requested: evictions blocked until the buffer empties
// S_DONE  | one-cycle flush_done_o pulse, then back to S_IDLE
module ibex_regcache_writeback #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Depth     = 4,
   parameter int unsigned AddrWidth = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     evict_valid_i,
   output logic                     evict_ready_o,
   input  logic [AddrWidth-1:0]     evict_addr_i,
   input  logic [DataWidth-1:0]     evict_data_i,
   output logic                     rf_we_o,
   output logic [AddrWidth-1:0]     rf_waddr_o,
   output logic [DataWidth-1:0]     rf_wdata_o,
   input  logic                     rf_gnt_i,
   input  logic [AddrWidth-1:0]     lookup_addr_i,
   output logic                     lookup_hit_o,
   output logic [DataWidth-1:0]     lookup_data_o,
   input  logic                     flush_i,
   output logic                     flush_done_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     stall_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e               r_state;
   state_e               w_state_nxt;
   logic [AddrWidth-1:0] r_addr [Depth];
   logic [DataWidth-1:0] r_data [Depth];
   logic [Depth-1:0]     r_valid;
   logic [PtrW-1:0]      r_rptr;
   logic [PtrW-1:0]      r_wptr;
   logic [CntW-1:0]      r_count;

   logic                 w_full;
   logic                 w_rf_we;
   logic                 w_pop;
   logic                 w_addr_nz;
   logic                 w_coal_hit;
   logic                 w_ready;
   logic                 w_push;
   logic                 w_alloc;
   logic                 w_flush_done;
   logic                 w_lk_hit;
   logic [DataWidth-1:0] w_lk_data;
   logic [PtrW-1:0]      w_idx;

   assign w_full    = (r_count == CntW'(Depth));
   assign w_rf_we   = (r_count != '0);
   assign w_pop     = w_rf_we && rf_gnt_i;
   assign w_addr_nz = (evict_addr_i != '0);

`ifdef REGCACHE_WB_COALESCE_EN
   logic [Depth-1:0] w_match;
   logic             w_coal;

   // A head entry leaving this cycle cannot absorb the push; it must allocate fresh.
   always_comb begin
      w_match = '0;
      for (int i = 0; i < Depth; i++) begin
         w_match[i] = r_valid[i] && (r_addr[i] == evict_addr_i)
                      && !(w_pop && (PtrW'(i) == r_rptr));
      end
   end

   assign w_coal_hit = w_addr_nz && (|w_match);
   assign w_coal     = w_push && w_coal_hit;
`else
   assign w_coal_hit = 1'b0;
`endif

   assign w_ready = (r_state != S_DRAIN) && (!w_full || w_pop || w_coal_hit);
   assign w_push  = evict_valid_i && w_ready;
   assign w_alloc = w_push && w_addr_nz && !w_coal_hit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < Depth; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_pop) begin
            r_valid[r_rptr] <= 1'b0;
            r_rptr          <= r_rptr + PtrW'(1);
         end
         if (w_alloc) begin
            r_valid[r_wptr] <= 1'b1;
            r_addr[r_wptr]  <= evict_addr_i;
            r_data[r_wptr]  <= evict_data_i;
            r_wptr          <= r_wptr + PtrW'(1);
         end
`ifdef REGCACHE_WB_COALESCE_EN
         for (int i = 0; i < Depth; i++) begin
            if (w_coal && w_match[i]) r_data[i] <= evict_data_i;
         end
`endif
         r_count <= r_count + CntW'(w_alloc) - CntW'(w_pop);
      end
   end

   // Walk oldest to youngest so the youngest match wins; a same-cycle push beats all.
   always_comb begin
      w_lk_hit  = 1'b0;
      w_lk_data = '0;
      w_idx     = '0;
      for (int k = 0; k < Depth; k++) begin
         w_idx = r_rptr + PtrW'(k);
         if (r_valid[w_idx] && (r_addr[w_idx] == lookup_addr_i)) begin
            w_lk_hit  = 1'b1;
            w_lk_data = r_data[w_idx];
         end
      end
      if (w_push && w_addr_nz && (evict_addr_i == lookup_addr_i)) begin
         w_lk_hit  = 1'b1;
         w_lk_data = evict_data_i;
      end
      if (lookup_addr_i == '0) begin
         w_lk_hit  = 1'b0;
         w_lk_data = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_flush_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (flush_i) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!flush_i)                 w_state_nxt = S_IDLE;
            else if (!w_rf_we && !w_pop)  w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_flush_done = 1'b1;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign evict_ready_o = w_ready;
   assign stall_o       = evict_valid_i && !w_ready;
   assign rf_we_o       = w_rf_we;
   assign rf_waddr_o    = w_rf_we ? r_addr[r_rptr] : '0;
   assign rf_wdata_o    = w_rf_we ? r_data[r_rptr] : '0;
   assign lookup_hit_o  = w_lk_hit;
   assign lookup_data_o = w_lk_data;
   assign flush_done_o  = w_flush_done;
   assign count_o       = r_count;

`ifndef SYNTHESIS
   a_no_alloc_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_alloc && w_full && !w_pop));
   a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_count <= CntW'(Depth));
   a_head_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (rf_we_o && !rf_gnt_i) |=> $stable(rf_waddr_o));
`ifndef REGCACHE_WB_COALESCE_EN
   // With coalescing the head data may legitimately be refreshed while stalled.
   a_head_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (rf_we_o && !rf_gnt_i) |=> $stable(rf_wdata_o));
`endif
`endif

endmodule

// File: tb/tb_ibex_regcache_writeback.sv
// Scoreboard bench for ibex_regcache_writeback: stimulus queues expected backing writes,
// a negedge monitor retires them; direct checks cover occupancy, bypass and flush.
module tb_ibex_regcache_writeback;

   localparam int DW = 32;
   localparam int DEP = 4;
   localparam int AW = 5;
`ifdef REGCACHE_WB_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            evict_valid_i = 1'b0;
   logic            evict_ready_o;
   logic [AW-1:0]   evict_addr_i = '0;
   logic [DW-1:0]   evict_data_i = '0;
   logic            rf_we_o;
   logic [AW-1:0]   rf_waddr_o;
   logic [DW-1:0]   rf_wdata_o;
   logic            rf_gnt_i = 1'b0;
   logic [AW-1:0]   lookup_addr_i = '0;
   logic            lookup_hit_o;
   logic [DW-1:0]   lookup_data_o;
   logic            flush_i = 1'b0;
   logic            flush_done_o;
   logic [$clog2(DEP):0] count_o;
   logic            stall_o;

   ibex_regcache_writeback #(.DataWidth(DW), .Depth(DEP), .AddrWidth(AW)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .evict_valid_i (evict_valid_i),
      .evict_ready_o (evict_ready_o),
      .evict_addr_i  (evict_addr_i),
      .evict_data_i  (evict_data_i),
      .rf_we_o       (rf_we_o),
      .rf_waddr_o    (rf_waddr_o),
      .rf_wdata_o    (rf_wdata_o),
      .rf_gnt_i      (rf_gnt_i),
      .lookup_addr_i (lookup_addr_i),
      .lookup_hit_o  (lookup_hit_o),
      .lookup_data_o (lookup_data_o),
      .flush_i       (flush_i),
      .flush_done_o  (flush_done_o),
      .count_o       (count_o),
      .stall_o       (stall_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_cmp = 0;
   int  n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // One-cycle eviction; queues the expected backing write when the entry should reach it.
   task automatic push(input logic [31:0] pa, input logic [31:0] pd, input bit expect_wr);
      evict_valid_i = 1'b1;
      evict_addr_i  = AW'(pa);
      evict_data_i  = pd;
      if (expect_wr) exp_q.push_back('{a: pa, d: pd});
      settle();
      chk("push_ready", 32'(evict_ready_o), 32'd1);
      tick();
      evict_valid_i = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (count_o != '0 && n < 50) begin
         tick();
         n++;
      end
      settle();
      chk(name, 32'(count_o), 32'd0);
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && rf_we_o && rf_gnt_i) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wr_unexpected: got addr %0d data 0x%0h, required no write",
                     rf_waddr_o, rf_wdata_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(rf_waddr_o), mon_e.a);
            chk("wr_data", rf_wdata_o, mon_e.d);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_we",    32'(rf_we_o), 32'd0);
      chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
      chk("rst_wdata", rf_wdata_o, 32'd0);
      chk("rst_hit",   32'(lookup_hit_o), 32'd0);
      chk("rst_ldata", lookup_data_o, 32'd0);
      chk("rst_done",  32'(flush_done_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_ready", 32'(evict_ready_o), 32'd1);
      rst_ni = 1'b1;
      tick();

      // single entry, 1-cycle latency, no pass-through
      rf_gnt_i      = 1'b1;
      evict_valid_i = 1'b1;
      evict_addr_i  = 5'd5;
      evict_data_i  = 32'hAAAA_0001;
      exp_q.push_back('{a: 32'd5, d: 32'hAAAA_0001});
      settle();
      chk("t1_no_passthru", 32'(rf_we_o), 32'd0);
      tick();
      evict_valid_i = 1'b0;
      settle();
      chk("t1_we",     32'(rf_we_o), 32'd1);
      chk("t1_count1", 32'(count_o), 32'd1);
      tick();
      settle();
      chk("t1_count0", 32'(count_o), 32'd0);
      chk("t1_we_off", 32'(rf_we_o), 32'd0);

      // fill to full, stall, then push-and-pop at the full boundary
      rf_gnt_i = 1'b0;
      for (int i = 1; i <= 4; i++) push(32'(i), 32'h1000 + 32'(i), 1'b1);
      settle();
      chk("t2_count_full", 32'(count_o), 32'd4);
      chk("t2_ready_full", 32'(evict_ready_o), 32'd0);
      evict_valid_i = 1'b1;
      evict_addr_i  = 5'd6;
      evict_data_i  = 32'h6006;
      settle();
      chk("t2_stall", 32'(stall_o), 32'd1);
      tick();
      settle();
      chk("t2_stall_hold", 32'(stall_o), 32'd1);
      chk("t2_count_hold", 32'(count_o), 32'd4);
      rf_gnt_i = 1'b1;
      settle();
      chk("t2_pop_ready", 32'(evict_ready_o), 32'd1);
      chk("t2_pop_stall", 32'(stall_o), 32'd0);
      exp_q.push_back('{a: 32'd6, d: 32'h6006});
      tick();
      evict_valid_i = 1'b0;
      settle();
      chk("t2_count_swap", 32'(count_o), 32'd4);
      wait_empty("t2_drain");

      // same address twice
      rf_gnt_i = 1'b0;
      push(32'd7, 32'h11, !COAL);
      push(32'd7, 32'h22, 1'b1);
      settle();
      chk("t3_count", 32'(count_o), COAL ? 32'd1 : 32'd2);
      lookup_addr_i = 5'd7;
      settle();
      chk("t3_hit",  32'(lookup_hit_o), 32'd1);
      chk("t3_data", lookup_data_o, 32'h22);
      lookup_addr_i = 5'd0;
      rf_gnt_i      = 1'b1;
      wait_empty("t3_drain");

      // bypass of a same-cycle push, x0 lookups and x0 evictions
      rf_gnt_i      = 1'b0;
      evict_valid_i = 1'b1;
      evict_addr_i  = 5'd9;
      evict_data_i  = 32'h33;
      lookup_addr_i = 5'd9;
      exp_q.push_back('{a: 32'd9, d: 32'h33});
      settle();
      chk("t4_bypass_hit",  32'(lookup_hit_o), 32'd1);
      chk("t4_bypass_data", lookup_data_o, 32'h33);
      lookup_addr_i = 5'd0;
      settle();
      chk("t4_zero_hit",  32'(lookup_hit_o), 32'd0);
      chk("t4_zero_data", lookup_data_o, 32'd0);
      tick();
      evict_valid_i = 1'b0;
      lookup_addr_i = 5'd9;
      settle();
      chk("t4_pend_hit",  32'(lookup_hit_o), 32'd1);
      chk("t4_pend_data", lookup_data_o, 32'h33);
      lookup_addr_i = 5'd3;
      settle();
      chk("t4_miss_hit",  32'(lookup_hit_o), 32'd0);
      chk("t4_miss_data", lookup_data_o, 32'd0);
      lookup_addr_i = 5'd0;
      push(32'd0, 32'hDEAD, 1'b0);
      settle();
      chk("t4_x0_count", 32'(count_o), 32'd1);
      rf_gnt_i = 1'b1;
      wait_empty("t4_drain");

      // flush with three pending entries: pulse four cycles after assertion
      rf_gnt_i = 1'b0;
      push(32'd10, 32'hA0, 1'b1);
      push(32'd11, 32'hB0, 1'b1);
      push(32'd12, 32'hC0, 1'b1);
      flush_i  = 1'b1;
      rf_gnt_i = 1'b1;
      tick();
      cyc = 1;
      settle();
      chk("t5_drain_ready", 32'(evict_ready_o), 32'd0);
      while (!flush_done_o && cyc < 30) begin
         tick();
         cyc++;
         settle();
      end
      chk("t5_done_cycle", 32'(cyc), 32'd4);
      chk("t5_done_count", 32'(count_o), 32'd0);
      flush_i = 1'b0;
      tick();
      settle();
      chk("t5_pulse_len", 32'(flush_done_o), 32'd0);

      // flush on empty buffer
      flush_i = 1'b1;
      settle();
      chk("t5e_c0", 32'(flush_done_o), 32'd0);
      tick();
      settle();
      chk("t5e_c1", 32'(flush_done_o), 32'd0);
      tick();
      settle();
      chk("t5e_c2", 32'(flush_done_o), 32'd1);
      flush_i = 1'b0;
      tick();
      settle();
      chk("t5e_c3", 32'(flush_done_o), 32'd0);

      // flush abandoned mid-drain
      rf_gnt_i = 1'b0;
      push(32'd14, 32'hE0, 1'b1);
      flush_i = 1'b1;
      tick();
      settle();
      chk("t6_drain_ready", 32'(evict_ready_o), 32'd0);
      flush_i = 1'b0;
      tick();
      settle();
      chk("t6_idle_ready", 32'(evict_ready_o), 32'd1);
      chk("t6_no_pulse0",  32'(flush_done_o), 32'd0);
      tick();
      settle();
      chk("t6_no_pulse1",  32'(flush_done_o), 32'd0);
      rf_gnt_i = 1'b1;
      wait_empty("t6_drain");

      // asynchronous reset mid-drain discards what remains
      rf_gnt_i = 1'b0;
      push(32'd20, 32'h2020, 1'b0);
      push(32'd21, 32'h2121, 1'b0);
      rf_gnt_i = 1'b1;
      exp_q.push_back('{a: 32'd20, d: 32'h2020});
      settle();
      chk("t7_count", 32'(count_o), 32'd2);
      tick();
      #1;
      rst_ni = 1'b0;
      #1;
      chk("t7_rst_we",    32'(rf_we_o), 32'd0);
      chk("t7_rst_count", 32'(count_o), 32'd0);
      chk("t7_rst_waddr", 32'(rf_waddr_o), 32'd0);
      lookup_addr_i = 5'd21;
      settle();
      chk("t7_rst_hit", 32'(lookup_hit_o), 32'd0);
      lookup_addr_i = 5'd0;
      tick();
      tick();
      rst_ni = 1'b1;
      repeat (5) tick();
      settle();
      chk("t7_post_we",    32'(rf_we_o), 32'd0);
      chk("t7_post_count", 32'(count_o), 32'd0);

      chk("q_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ibex_regcache_writeback.md
Name: ibex_regcache_writeback

Overview:
- Write-back drain unit on the backing-store side of the register-file write cache.
- Accepts dirty entries evicted from the register cache and buffers them in a small FIFO.
- Retires buffered entries to the backing flop register file, one write per granted cycle.
- Provides read bypass for pending entries and a flush handshake, so the cache can stall the core only when the buffer is full.

Parameters:
- DataWidth, 32, width of a register value.
- Depth, 4, number of pending write-back entries; must be a power of two, ≥2.
- AddrWidth, 5, register address width; 4 when RV32E.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- evict_valid_i  input  1  eviction request from register cache.
- evict_ready_o  output  1  buffer can accept eviction this cycle.
- evict_addr_i  input  AddrWidth  evicted register address.
- evict_data_i  input  DataWidth  evicted register value.
- rf_we_o  output  1  backing register file write request.
- rf_waddr_o  output  AddrWidth  backing write address (FIFO head).
- rf_wdata_o  output  DataWidth  backing write data (FIFO head).
- rf_gnt_i  input  1  backing write port accepts rf_we_o this cycle.
- lookup_addr_i  input  AddrWidth  read-bypass address from cache miss path.
- lookup_hit_o  output  1  lookup_addr_i pending in buffer.
- lookup_data_o  output  DataWidth  pending value; 0 when no hit.
- flush_i  input  1  request full drain (level, held until flush_done_o).
- flush_done_o  output  1  one-cycle pulse, buffer empty after flush.
- count_o  output  $clog2(Depth)+1  occupancy.
- stall_o  output  1  evict_valid_i && !evict_ready_o.

Behaviour:
- Reset values:
  - Outputs: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, lookup_hit_o=0, lookup_data_o=0, flush_done_o=0, count_o=0, stall_o=0.
  - Internal: evict_ready_o=1, FSM=IDLE, read/write pointers=0, all entry valid bits cleared.
- Push (accept) occurs when evict_valid_i && evict_ready_o; the entry is visible at the head no earlier than the next cycle (1-cycle latency).
- Evictions to address 0 are accepted and dropped: no entry, no count change.
- Drain:
  - rf_we_o = (count_o != 0); waddr/wdata come combinationally from the head entry.
  - Pop on rf_we_o && rf_gnt_i; the head advances next cycle.
- Full boundary: evict_ready_o = !full || (rf_we_o && rf_gnt_i). Push and pop in the same cycle when full leaves count unchanged.
- Empty boundary: a push into an empty buffer is not written out in the same cycle (no combinational pass-through to rf_*).
- Pointers wrap modulo Depth; count_o ranges 0..Depth.
- Coalescing (see Optional Feature):
  - A push whose address matches a pending entry overwrites that entry's data; no allocation, count unchanged, evict_ready_o=1 even when full.
  - Exception: if the match is the head and it is popped in the same cycle, the push allocates a new entry instead.
- Lookup (combinational):
  - Hit if any pending entry matches lookup_addr_i, or if the same-cycle accepted push matches.
  - Priority: same-cycle push > youngest pending entry.
  - lookup_addr_i=0 never hits.
- Flush FSM:
  - IDLE→DRAIN when flush_i=1.
  - In DRAIN, evict_ready_o is forced to 0.
  - DRAIN→DONE when count_o==0 and no pop is in flight.
  - DONE drives flush_done_o=1 for one cycle, then →IDLE.
  - flush_i asserted with an empty buffer: IDLE→DRAIN→DONE (pulse 2 cycles after assertion).
  - Dropping flush_i mid-DRAIN returns to IDLE next cycle with no pulse.
- Reset mid-operation: all pending entries are discarded, FSM→IDLE; no write is issued in the reset cycle.
- Assertions:
  - No push when evict_ready_o=0.
  - count_o ≤ Depth.
  - Stable rf_waddr_o/rf_wdata_o while rf_we_o && !rf_gnt_i.

Optional Feature:
- Macro: REGCACHE_WB_COALESCE_EN.
- Defined: coalescing as described; at most one pending entry per address.
- Undefined: every non-zero push allocates a new entry; duplicate addresses may be pending. Lookup returns the youngest match. Drain order is strict FIFO, so the backing file ends with the last value.

Test Plan:
- Reset, then push x5=0xAAAA_0001 with rf_gnt_i=1 → rf_we_o high cycle+1 with waddr=5, wdata=0xAAAA_0001; count returns to 0 after cycle+2.
- rf_gnt_i=0, push x1..x4 → count_o=4, evict_ready_o=0, stall_o=1 on a 5th push to x6; raise gnt → x1,x2,x3,x4 written in order; x6 accepted in the first pop cycle.
- COALESCE_EN, gnt=0, push x7=0x11 then x7=0x22 → count_o=1, lookup x7 hit with 0x22; drain writes 0x22 once. Without macro: count_o=2, writes 0x11 then 0x22, lookup gives 0x22.
- Push x9=0x33 while lookup_addr_i=9 in the same cycle → lookup_hit_o=1, data=0x33; lookup_addr_i=0 → hit=0, data=0.
- Three entries pending, flush_i=1, gnt=1 → evict_ready_o=0 during drain, three writes, flush_done_o pulses once; flush on empty buffer → pulse 2 cycles later.
- Two entries pending, assert rst_ni=0 asynchronously mid-drain → rf_we_o=0 and count_o=0 immediately; no further writes after release.
